// File: rtl/field_lock_writer.sv
// rtl/field_lock_writer.sv - 20x20 playfield owner: locks a 4x4 piece, then clears full rows
// Optional feature macro: FIELD_LOCK_LINE_CLEAR_EN (builds SCAN/SHIFT row clearing).
module field_lock_writer (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         clear_field,
    input  logic [0:15]  block,
    input  logic [4:0]   blockX,
    input  logic [4:0]   blockY,
    output logic [0:399] field,
    output logic         busy,
    output logic         done,
    output logic [2:0]   lines_cleared,
    output logic         lock_err
);

`ifdef FIELD_LOCK_LINE_CLEAR_EN
    typedef enum logic [2:0] {S_IDLE, S_LOCK, S_SCAN, S_SHIFT, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOCK, S_DONE} state_t;
`endif

    state_t         state_q, state_d;
    logic [0:399]   field_q, field_d;
    logic [0:15]    blk_q, blk_d;
    logic [4:0]     bx_q, bx_d;
    logic [4:0]     by_q, by_d;
    logic           lerr_q, lerr_d;
    logic [0:399]   lock_field;
    logic           lock_bad;
`ifdef FIELD_LOCK_LINE_CLEAR_EN
    logic [4:0]     row_q, row_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic [2:0]     lines_q, lines_d;
    logic [0:399]   shift_field;
    logic [8:0]     row_base;
    logic           row_full;
`endif

    // Piece write: OR every in-range set cell into the field; out-of-range cells only flag an error
    always_comb begin
        logic [5:0] r6;
        logic [5:0] c6;
        logic [8:0] idx;
        lock_field = field_q;
        lock_bad   = 1'b0;
        r6         = '0;
        c6         = '0;
        idx        = '0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (blk_q[y*4+x]) begin
                    r6 = {1'b0, by_q} + 6'(y);
                    c6 = {1'b0, bx_q} + 6'(x);
                    if (r6 > 6'd19 || c6 > 6'd19) begin
                        lock_bad = 1'b1;
                    end else begin
                        idx = {3'b0, r6} * 9'd20 + {3'b0, c6};
                        lock_field[idx] = 1'b1;
                    end
                end
            end
        end
    end

`ifdef FIELD_LOCK_LINE_CLEAR_EN
    // Row test and drop-by-one of every row at or above the row pointer
    always_comb begin
        row_base    = {4'b0, row_q} * 9'd20;
        row_full    = &field_q[row_base +: 20];
        shift_field = field_q;
        shift_field[0 +: 20] = '0;
        for (int i = 1; i < 20; i++) begin
            if (5'(i) <= row_q) begin
                shift_field[i*20 +: 20] = field_q[(i-1)*20 +: 20];
            end
        end
    end
`endif

    // Next-state and datapath updates for the lock/scan/shift sequence
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        blk_d   = blk_q;
        bx_d    = bx_q;
        by_d    = by_q;
        lerr_d  = lerr_q;
`ifdef FIELD_LOCK_LINE_CLEAR_EN
        row_d   = row_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        lines_d = lines_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (clear_field) begin
                    field_d = '0;
                end else if (start) begin
                    blk_d   = block;
                    bx_d    = blockX;
                    by_d    = blockY;
`ifdef FIELD_LOCK_LINE_CLEAR_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                field_d = lock_field;
`ifdef FIELD_LOCK_LINE_CLEAR_EN
                err_d   = lock_bad;
                row_d   = 5'd19;
                state_d = S_SCAN;
`else
                lerr_d  = lock_bad;
                state_d = S_DONE;
`endif
            end
`ifdef FIELD_LOCK_LINE_CLEAR_EN
            S_SCAN: begin
                if (row_full) begin
                    state_d = S_SHIFT;
                end else if (row_q != 5'd0) begin
                    row_d = row_q - 5'd1;
                end else begin
                    lines_d = cnt_q;
                    lerr_d  = err_q;
                    state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                field_d = shift_field;
                cnt_d   = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
                state_d = S_SCAN;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation and wipes the field
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            field_q <= '0;
            blk_q   <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            lerr_q  <= 1'b0;
`ifdef FIELD_LOCK_LINE_CLEAR_EN
            row_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            lines_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            field_q <= field_d;
            blk_q   <= blk_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            lerr_q  <= lerr_d;
`ifdef FIELD_LOCK_LINE_CLEAR_EN
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            lines_q <= lines_d;
`endif
        end
    end

    assign field    = field_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign lock_err = lerr_q;
`ifdef FIELD_LOCK_LINE_CLEAR_EN
    assign lines_cleared = lines_q;
`else
    assign lines_cleared = 3'd0;
`endif

endmodule
